// File: rtl/des_pkg.sv
// des_pkg: shared constants and helpers for the iterative DES engines.
//
// Bit numbering used throughout: vector bit k holds DES bit k+1, so every
// standard DES table (1-based, "output bit i takes input bit T[i]") maps
// directly onto out[i-1] = in[T[i]-1].
//
// Contents:
//   des_state_e            engine FSM state type
//   IP/FP/PC1/PC2/E/P      permutation index tables (1-based DES bit numbers)
//   SBOX[8][64]            S-box contents, index = {row[1:0], col[3:0]}
//   SHIFT_DEC / SHIFT_ENC  key-schedule rotation amounts indexed by round
//   des_ip .. des_p        permutation helpers
//   rot_dec / rot_enc      28-bit key-half rotations
package des_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRound,
        StDone
    } des_state_e;

    localparam int IP_TBL [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_TBL [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam int E_TBL [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int P_TBL [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // Row-major: entry row*16 + col.
    localparam int unsigned SBOX [8][64] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
    };

    // Decrypt rotation applied after round n; the last round needs none.
    localparam int unsigned SHIFT_DEC [16] = '{1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1, 0};
    // Encrypt rotation applied before round n.
    localparam int unsigned SHIFT_ENC [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic logic [63:0] des_ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[i] = x[IP_TBL[i] - 1];
        return y;
    endfunction

    function automatic logic [63:0] des_fp(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[i] = x[FP_TBL[i] - 1];
        return y;
    endfunction

    function automatic logic [55:0] des_pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[i] = x[PC1_TBL[i] - 1];
        return y;
    endfunction

    function automatic logic [47:0] des_pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[i] = x[PC2_TBL[i] - 1];
        return y;
    endfunction

    function automatic logic [47:0] des_e(input logic [31:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[i] = x[E_TBL[i] - 1];
        return y;
    endfunction

    function automatic logic [31:0] des_p(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) y[i] = x[P_TBL[i] - 1];
        return y;
    endfunction

    // Decrypt direction: DES bit 28 wraps to DES bit 1 (vector rotates up).
    function automatic logic [27:0] rot_dec(input logic [27:0] x, input int unsigned n);
        case (n)
            1:       return {x[26:0], x[27]};
            2:       return {x[25:0], x[27:26]};
            default: return x;
        endcase
    endfunction

    // Encrypt direction: DES bit 1 wraps to DES bit 28 (vector rotates down).
    function automatic logic [27:0] rot_enc(input logic [27:0] x, input int unsigned n);
        case (n)
            1:       return {x[0], x[27:1]};
            2:       return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

endpackage

// File: rtl/des_f_function.sv
// des_f_function: combinational DES round function f(R, K).
// E-expands R to 48 bits, XORs the subkey, substitutes through the eight
// S-boxes and applies P. Vector bit k = DES bit k+1 on every port.
//
// Ports:
//   r_i [31:0]  right half
//   k_i [47:0]  round subkey
//   f_o [31:0]  f(R, K)
module des_f_function
    import des_pkg::*;
(
    input  logic [31:0] r_i,
    input  logic [47:0] k_i,
    output logic [31:0] f_o
);

    logic [47:0] x;
    logic [31:0] s;
    logic [5:0]  idx;
    logic [3:0]  val;

    always_comb begin
        x   = des_e(r_i) ^ k_i;
        s   = '0;
        idx = '0;
        val = '0;
        for (int j = 0; j < 8; j++) begin
            // Row = outer bits (DES b1,b6), column = inner bits b2..b5.
            idx = {x[6*j], x[6*j+5], x[6*j+1], x[6*j+2], x[6*j+3], x[6*j+4]};
            val = 4'(SBOX[j][idx]);
            // S-box MSB is the lowest-numbered DES bit of the nibble.
            s[4*j]   = val[3];
            s[4*j+1] = val[2];
            s[4*j+2] = val[1];
            s[4*j+3] = val[0];
        end
        f_o = des_p(s);
    end

endmodule

// File: rtl/des_decrypt_iter.sv
// des_decrypt_iter: iterative DES decryption, one Feistel round per clock.
// A block accepted in IDLE runs 16 rounds with the key schedule walked
// backwards (K16 first); the plaintext is registered one cycle after the
// last round and held until the downstream handshake completes.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_valid / o_ready   input handshake (o_ready high only in IDLE)
//   i_data  [63:0]      ciphertext, vector bit k = DES bit k+1
//   i_key   [63:0]      key incl. parity bits (parity ignored)
//   o_valid / i_ready   output handshake
//   o_data  [63:0]      plaintext
//   i_encrypt           only when DES_ENCRYPT_EN is defined: 1 selects
//                       encryption, sampled with the input handshake
module des_decrypt_iter
    import des_pkg::*;
#(
    parameter int unsigned ROUND_CNT_W = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [63:0] i_data,
    input  logic [63:0] i_key,
    output logic        o_valid,
    input  logic        i_ready,
`ifdef DES_ENCRYPT_EN
    input  logic        i_encrypt,
`endif
    output logic [63:0] o_data
);

    localparam logic [ROUND_CNT_W-1:0] LastRound = ROUND_CNT_W'(15);

    des_state_e             state_q;
    logic [ROUND_CNT_W-1:0] cnt_q;
    logic [31:0]            l_q, r_q;
    logic [27:0]            c_q, d_q;
    logic                   o_valid_q;
    logic [63:0]            o_data_q;
`ifdef DES_ENCRYPT_EN
    logic                   enc_q;
`endif

    logic [63:0] ip_in;
    logic [55:0] pc1_key;
    logic [27:0] c_key, d_key, c_nxt, d_nxt;
    logic [47:0] subkey;
    logic [31:0] f_out;

    // PC1 never selects the parity bits.
    logic unused_key_parity;
    assign unused_key_parity = ^{i_key[63], i_key[55], i_key[47], i_key[39],
                                 i_key[31], i_key[23], i_key[15], i_key[7]};

    assign ip_in   = des_ip(i_data);
    assign pc1_key = des_pc1(i_key);

    // Decrypt uses C/D as stored and rotates afterwards; encrypt rotates
    // first and keeps the rotated halves.
    always_comb begin
        c_key = c_q;
        d_key = d_q;
        c_nxt = rot_dec(c_q, SHIFT_DEC[cnt_q]);
        d_nxt = rot_dec(d_q, SHIFT_DEC[cnt_q]);
`ifdef DES_ENCRYPT_EN
        if (enc_q) begin
            c_key = rot_enc(c_q, SHIFT_ENC[cnt_q]);
            d_key = rot_enc(d_q, SHIFT_ENC[cnt_q]);
            c_nxt = c_key;
            d_nxt = d_key;
        end
`endif
        subkey = des_pc2({d_key, c_key});
    end

    des_f_function u_f (
        .r_i (r_q),
        .k_i (subkey),
        .f_o (f_out)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            l_q       <= '0;
            r_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
`ifdef DES_ENCRYPT_EN
            enc_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_valid) begin
                        l_q     <= ip_in[31:0];
                        r_q     <= ip_in[63:32];
                        c_q     <= pc1_key[27:0];
                        d_q     <= pc1_key[55:28];
                        cnt_q   <= '0;
`ifdef DES_ENCRYPT_EN
                        enc_q   <= i_encrypt;
`endif
                        state_q <= StRound;
                    end
                end
                StRound: begin
                    l_q   <= r_q;
                    r_q   <= l_q ^ f_out;
                    c_q   <= c_nxt;
                    d_q   <= d_nxt;
                    // Wraps back to 0 after the last round.
                    cnt_q <= cnt_q + ROUND_CNT_W'(1);
                    if (cnt_q == LastRound) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (!o_valid_q) begin
                        // l_q/r_q hold L16/R16; preoutput is R16||L16.
                        o_data_q  <= des_fp({l_q, r_q});
                        o_valid_q <= 1'b1;
                    end else if (i_ready) begin
                        o_valid_q <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_ready = (state_q == StIdle);
    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;

endmodule
